// File: rtl/sobel_pkg.sv
// Shared constants and helpers for the streaming Sobel edge detector.
package sobel_pkg;

    // Gradient width: a signed sum of four weighted pixel differences needs three extra bits.
    function automatic int unsigned sob_grad_w(input int unsigned pix_w);
        return pix_w + 3;
    endfunction

    // Window positions: p0 p1 p2 / p3 p4 p5 / p6 p7 p8, p2/p5/p8 newest column.
    localparam int unsigned P0    = 0;
    localparam int unsigned P1    = 1;
    localparam int unsigned P2    = 2;
    localparam int unsigned P3    = 3;
    localparam int unsigned P4    = 4;
    localparam int unsigned P5    = 5;
    localparam int unsigned P6    = 6;
    localparam int unsigned P7    = 7;
    localparam int unsigned P8    = 8;
    localparam int unsigned WIN_N = 9;

    // Clamp a magnitude to pix_w bits: all-ones if any higher bit is set.
    function automatic logic [31:0] saturate(input logic [31:0] mag, input int unsigned pix_w);
        logic [31:0] ones;
        ones = (32'd1 << pix_w) - 32'd1;
        return ((mag & ~ones) != 32'd0) ? ones : mag;
    endfunction

endpackage

// File: rtl/sobel_stream_if.sv
// Pixel-in / edge-out stream bundle for sobel_stream (no backpressure).
interface sobel_stream_if #(
    parameter int unsigned PIX_W = 8
);
    logic             in_valid;
    logic             in_sof;
    logic [PIX_W-1:0] in_data;
    logic [PIX_W-1:0] thresh;
    logic             out_valid;
    logic [PIX_W-1:0] out_data;

    modport master (
        output in_valid, in_sof, in_data, thresh,
        input  out_valid, out_data
    );

    modport slave (
        input  in_valid, in_sof, in_data, thresh,
        output out_valid, out_data
    );
endinterface

// File: rtl/sobel_line_buf.sv
// One-line delay: the value read at column addr is the pixel written there one line earlier.
module sobel_line_buf #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned IMG_W = 640,
    localparam int unsigned AW   = $clog2(IMG_W)
) (
    input  logic             clk,
    input  logic             en,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] rd_c
);
    // Line storage; contents are intentionally not reset.
    logic [PIX_W-1:0] mem [IMG_W];

    // Read-before-write: old value is visible on the same beat that overwrites it.
    assign rd_c = mem[addr];

    // Write the incoming pixel on each accepted beat.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= din;
        end
    end
endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector: one pixel per valid beat, |gx|+|gy| per interior pixel.
// Optional build macro SOBEL_THRESH_EN: output becomes binary (all-ones if magnitude >= thresh).
module sobel_stream
    import sobel_pkg::*;
#(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480
) (
    input  logic           clk,
    input  logic           rst_n,
    sobel_stream_if.slave  s
);
    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);
    localparam int unsigned GW = sob_grad_w(PIX_W);

    logic [CW-1:0]          col_q, col_cur_c;
    logic [RW-1:0]          row_q, row_cur_c;
    logic                   win_done_c;
    logic [PIX_W-1:0]       rd0_c, rd1_c;
    logic [PIX_W-1:0]       newcol_c [3];
    logic [PIX_W-1:0]       c1_q [3];
    logic [PIX_W-1:0]       c2_q [3];
    logic [PIX_W-1:0]       win_c [WIN_N];
    logic signed [GW-1:0]   e_c [WIN_N];
    logic signed [GW-1:0]   gx_c, gy_c, gx_q, gy_q;
    logic                   s1_v_q;
    logic [GW-1:0]          ax_c, ay_c, mag_c;
    logic [PIX_W-1:0]       sat_c, res_c;

    // A start-of-frame beat is position (0,0) regardless of counter state.
    assign col_cur_c  = s.in_sof ? '0 : col_q;
    assign row_cur_c  = s.in_sof ? '0 : row_q;
    assign win_done_c = s.in_valid && (row_cur_c >= RW'(2)) && (col_cur_c >= CW'(2));

    // Raster position counters, advanced per accepted pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else if (s.in_valid) begin
            if (col_cur_c == CW'(IMG_W - 1)) begin
                col_q <= '0;
                row_q <= (row_cur_c == RW'(IMG_H - 1)) ? '0 : row_cur_c + RW'(1);
            end else begin
                col_q <= col_cur_c + CW'(1);
                row_q <= row_cur_c;
            end
        end
    end

    // Two chained line delays: row r -> r-1 -> r-2.
    sobel_line_buf #(.PIX_W(PIX_W), .IMG_W(IMG_W)) u_lb0 (
        .clk  (clk),
        .en   (s.in_valid),
        .addr (col_cur_c),
        .din  (s.in_data),
        .rd_c (rd0_c)
    );

    sobel_line_buf #(.PIX_W(PIX_W), .IMG_W(IMG_W)) u_lb1 (
        .clk  (clk),
        .en   (s.in_valid),
        .addr (col_cur_c),
        .din  (rd0_c),
        .rd_c (rd1_c)
    );

    // Newest window column comes straight from the input and line buffer taps (index 0 = top row).
    assign newcol_c[0] = rd1_c;
    assign newcol_c[1] = rd0_c;
    assign newcol_c[2] = s.in_data;

    // Two older window columns shift along on every accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                c1_q[i] <= '0;
                c2_q[i] <= '0;
            end
        end else if (s.in_valid) begin
            for (int i = 0; i < 3; i++) begin
                c2_q[i] <= c1_q[i];
                c1_q[i] <= newcol_c[i];
            end
        end
    end

    // Assemble the 3x3 window and zero-extend into the signed gradient domain.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            win_c[3*i]     = c2_q[i];
            win_c[3*i + 1] = c1_q[i];
            win_c[3*i + 2] = newcol_c[i];
        end
        for (int k = 0; k < WIN_N; k++) begin
            e_c[k] = $signed(GW'(win_c[k]));
        end
    end

    // Sobel kernels; magnitudes stay within GW signed bits.
    assign gx_c = (e_c[P2] - e_c[P0]) + ((e_c[P5] - e_c[P3]) <<< 1) + (e_c[P8] - e_c[P6]);
    assign gy_c = (e_c[P0] - e_c[P6]) + ((e_c[P1] - e_c[P7]) <<< 1) + (e_c[P2] - e_c[P8]);

    // Stage 1: register gradients for complete windows; a restart beat never completes one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q <= 1'b0;
            gx_q   <= '0;
            gy_q   <= '0;
        end else begin
            s1_v_q <= win_done_c;
            if (win_done_c) begin
                gx_q <= gx_c;
                gy_q <= gy_c;
            end
        end
    end

    // Absolute values, sum and saturation to pixel width.
    assign ax_c  = gx_q[GW-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
    assign ay_c  = gy_q[GW-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
    assign mag_c = ax_c + ay_c;
    assign sat_c = PIX_W'(saturate(32'(mag_c), PIX_W));

`ifdef SOBEL_THRESH_EN
    // Binary edge map against the runtime threshold.
    assign res_c = (sat_c >= s.thresh) ? '1 : '0;
`else
    // Threshold is ignored; keep the port observed for lint.
    logic unused_thresh_c;
    assign unused_thresh_c = ^s.thresh;
    assign res_c = sat_c;
`endif

    // Stage 2: registered output; a start-of-frame beat squashes in-flight results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s.out_valid <= 1'b0;
            s.out_data  <= '0;
        end else begin
            s.out_valid <= s1_v_q && !(s.in_valid && s.in_sof);
            if (s1_v_q) begin
                s.out_data <= res_c;
            end
        end
    end
endmodule
